// File: rtl/data_ram_arbiter_pkg.sv
// Shared widths, state encoding and defaults
// for the data RAM arbiter slice.
package data_ram_arbiter_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;

  localparam int MAX_HOLD_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

endpackage

// File: rtl/data_ram_arbiter_if.sv
// One requesting master's view of the data RAM:
// request/lock qualifiers, access fields, ack and read data.
interface data_ram_arbiter_if;
  import data_ram_arbiter_pkg::*;

  logic              req;
  logic              lock;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (
    output req, lock, we,
    output addr, sel, wdata,
    input  rdata, ack
  );

  modport slave (
    input  req, lock, we,
    input  addr, sel, wdata,
    output rdata, ack
  );

endinterface

// File: rtl/data_ram_arbiter_port_mux.sv
// Owner-select mux: steers the owning master onto the
// RAM pins and returns ack/rdata to that master only.
module arb_port_mux
  import data_ram_arbiter_pkg::*;
(
  input  logic              own0,
  input  logic              own1,
  data_ram_arbiter_if.slave m0,
  data_ram_arbiter_if.slave m1,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [SEL_W-1:0]  ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o
);

  always_comb begin
    ram_ce_o   = 1'b0;
    ram_we_o   = 1'b0;
    ram_addr_o = '0;
    ram_sel_o  = '0;
    ram_data_o = '0;
    m0.ack     = 1'b0;
    m0.rdata   = '0;
    m1.ack     = 1'b0;
    m1.rdata   = '0;
    unique case (1'b1)
      own0: begin
        ram_ce_o = m0.req;
        m0.ack   = m0.req;
        m0.rdata = ram_data_i;
        if (m0.req) begin
          ram_we_o   = m0.we;
          ram_addr_o = m0.addr;
          ram_sel_o  = m0.sel;
          ram_data_o = m0.wdata;
        end
      end
      own1: begin
        ram_ce_o = m1.req;
        m1.ack   = m1.req;
        m1.rdata = ram_data_i;
        if (m1.req) begin
          ram_we_o   = m1.we;
          ram_addr_o = m1.addr;
          ram_sel_o  = m1.sel;
          ram_data_o = m1.wdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Two-master data RAM arbiter: round-robin on ties,
// bounded hold with lock override, zero-latency owner path.
module data_ram_arbiter
  import data_ram_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  data_ram_arbiter_if.slave m0,
  data_ram_arbiter_if.slave m1,
  input  logic [DATA_W-1:0] ram_data_i,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [SEL_W-1:0]  ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o
);

  localparam int CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_HOLD);

  arb_state_e    state, state_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_inc;
  logic          own_req, oth_req, own_lock;
  arb_state_e    oth_state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    cnt_nxt   = cnt;
    own_req   = (state == OWN1) ? m1.req  : m0.req;
    own_lock  = (state == OWN1) ? m1.lock : m0.lock;
    oth_req   = (state == OWN1) ? m0.req  : m1.req;
    oth_state = (state == OWN1) ? OWN0    : OWN1;
    cnt_inc   = (cnt == MAX_C) ? cnt : cnt + CW'(1);
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (m0.req && m1.req)
          state_nxt = last ? OWN0 : OWN1;
        else if (m0.req)
          state_nxt = OWN0;
        else if (m1.req)
          state_nxt = OWN1;
      end
      OWN0, OWN1: begin
        // cnt_inc counts the access acked this
        // cycle, so the switch follows that ack
        if (!own_req) begin
          last_nxt  = (state == OWN1);
          state_nxt = oth_req ? oth_state : IDLE;
          cnt_nxt   = '0;
        end else if (cnt_inc == MAX_C &&
                     oth_req && !own_lock) begin
          last_nxt  = (state == OWN1);
          state_nxt = oth_state;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  arb_port_mux u_mux (
    .own0       (state == OWN0),
    .own1       (state == OWN1),
    .m0         (m0),
    .m1         (m1),
    .ram_data_i (ram_data_i),
    .ram_ce_o   (ram_ce_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_sel_o  (ram_sel_o),
    .ram_data_o (ram_data_o)
  );

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed + random bench for data_ram_arbiter against
// an ownership/round-robin reference model.
module tb_data_ram_arbiter;
  import data_ram_arbiter_pkg::*;

  localparam int MH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        clr = 1'b0;
  logic        ram_ce_o, ram_we_o;
  logic [31:0] ram_addr_o, ram_data_o, ram_data_i;
  logic [3:0]  ram_sel_o;

  data_ram_arbiter_if m0_if ();
  data_ram_arbiter_if m1_if ();

  data_ram_arbiter #(.MAX_HOLD(MH)) dut (
    .clk        (clk),
    .rst        (rst),
    .m0         (m0_if),
    .m1         (m1_if),
    .ram_data_i (ram_data_i),
    .ram_ce_o   (ram_ce_o),
    .ram_we_o   (ram_we_o),
    .ram_addr_o (ram_addr_o),
    .ram_sel_o  (ram_sel_o),
    .ram_data_o (ram_data_o)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [256];
  logic [31:0] ref_mem [256];

  assign ram_data_i = mem[ram_addr_o[9:2]];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (ram_ce_o && ram_we_o) begin
      for (int b = 0; b < 4; b++)
        if (ram_sel_o[b])
          mem[ram_addr_o[9:2]][8*b +: 8] <= ram_data_o[8*b +: 8];
    end
  end

  int checks = 0;
  int errors = 0;
  int owner, last, cnt;
  int ack0_n, ack1_n;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(
      input logic [31:0] old, wd, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (s[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  task automatic set_m(input int i, input logic rq, lk, w,
                       input logic [31:0] a,
                       input logic [3:0] s,
                       input logic [31:0] d);
    if (i == 0) begin
      m0_if.req = rq; m0_if.lock = lk; m0_if.we = w;
      m0_if.addr = a; m0_if.sel = s; m0_if.wdata = d;
    end else begin
      m1_if.req = rq; m1_if.lock = lk; m1_if.we = w;
      m1_if.addr = a; m1_if.sel = s; m1_if.wdata = d;
    end
  endtask

  task automatic model_reset();
    owner = -1;
    last  = 1;
    cnt   = 0;
  endtask

  // expected pins follow from who owns the RAM right now
  task automatic check_outputs();
    logic        oreq, owe;
    logic [31:0] oaddr, owd, ea, erd;
    logic [3:0]  osel;
    oreq = 0; owe = 0; oaddr = 0; owd = 0; osel = 0;
    if (owner == 0) begin
      oreq = m0_if.req; owe = m0_if.we; oaddr = m0_if.addr;
      osel = m0_if.sel; owd = m0_if.wdata;
    end else if (owner == 1) begin
      oreq = m1_if.req; owe = m1_if.we; oaddr = m1_if.addr;
      osel = m1_if.sel; owd = m1_if.wdata;
    end
    ea  = oreq ? oaddr : 32'h0;
    erd = ref_mem[ea[9:2]];
    chk("ce",    {31'b0, ram_ce_o}, {31'b0, oreq});
    chk("we",    {31'b0, ram_we_o}, {31'b0, oreq & owe});
    chk("addr",  ram_addr_o, ea);
    chk("sel",   {28'b0, ram_sel_o}, oreq ? {28'b0, osel} : 0);
    chk("wdata", ram_data_o, oreq ? owd : 32'h0);
    chk("ack0",  {31'b0, m0_if.ack},
                 {31'b0, owner == 0 && oreq});
    chk("ack1",  {31'b0, m1_if.ack},
                 {31'b0, owner == 1 && oreq});
    chk("rdata0", m0_if.rdata, owner == 0 ? erd : 32'h0);
    chk("rdata1", m1_if.rdata, owner == 1 ? erd : 32'h0);
    ack0_n += int'(m0_if.ack);
    ack1_n += int'(m1_if.ack);
  endtask

  task automatic model_step();
    logic rq [2], lk [2], w [2];
    logic [31:0] a [2], d [2];
    logic [3:0]  s [2];
    int o, p;
    rq[0] = m0_if.req;  rq[1] = m1_if.req;
    lk[0] = m0_if.lock; lk[1] = m1_if.lock;
    w[0]  = m0_if.we;   w[1]  = m1_if.we;
    a[0]  = m0_if.addr; a[1]  = m1_if.addr;
    d[0]  = m0_if.wdata; d[1] = m1_if.wdata;
    s[0]  = m0_if.sel;  s[1]  = m1_if.sel;
    if (owner < 0) begin
      if (rq[0] && rq[1]) owner = (last == 1) ? 0 : 1;
      else if (rq[0])     owner = 0;
      else if (rq[1])     owner = 1;
      cnt = 0;
    end else begin
      o = owner;
      p = 1 - o;
      if (!rq[o]) begin
        last  = o;
        owner = rq[p] ? p : -1;
        cnt   = 0;
      end else begin
        if (w[o])
          ref_mem[a[o][9:2]] = merge(ref_mem[a[o][9:2]],
                                     d[o], s[o]);
        cnt = (cnt < MH) ? cnt + 1 : MH;
        if (cnt == MH && rq[p] && !lk[o]) begin
          last  = o;
          owner = p;
          cnt   = 0;
        end
      end
    end
  endtask

  // called just after a falling edge with inputs set
  task automatic cycle();
    #1;
    check_outputs();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    set_m(0, 0, 0, 0, 0, 0, 0);
    set_m(1, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    rst = 1'b1;
    clr = 1'b1;
    set_m(0, 1, 0, 1, 32'h10, 4'hF, 32'h1111_1111);
    set_m(1, 1, 0, 1, 32'h14, 4'hF, 32'h2222_2222);
    #1;
    check_outputs();
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    rst = 1'b0;

    // tie after reset goes to m0, one cycle latency
    set_m(0, 1, 0, 0, 32'h0, 4'hF, 0);
    set_m(1, 1, 0, 0, 32'h4, 4'hF, 0);
    cycle();
    #1;
    chk("r036_ack0", {31'b0, m0_if.ack}, 32'd1);
    chk("r036_ack1", {31'b0, m1_if.ack}, 32'd0);
    cycle();

    // m1 write, release, m0 read back
    set_m(0, 0, 0, 0, 0, 0, 0);
    set_m(1, 1, 0, 1, 32'h40, 4'hF, 32'hDEAD_BEEF);
    cycle();
    cycle();
    set_m(1, 0, 0, 0, 0, 0, 0);
    set_m(0, 1, 0, 0, 32'h40, 4'hF, 0);
    cycle();
    #1;
    chk("r037_ack0", {31'b0, m0_if.ack}, 32'd1);
    chk("r037_rdata", m0_if.rdata, 32'hDEAD_BEEF);
    cycle();

    // MAX_HOLD alternation: 4 acks each, no gaps
    do_reset();
    set_m(0, 1, 0, 0, 32'h8, 4'hF, 0);
    set_m(1, 1, 0, 0, 32'hC, 4'hF, 0);
    cycle();
    ack0_n = 0; ack1_n = 0;
    for (int i = 0; i < 40; i++) cycle();
    chk("r038_acks0", ack0_n, 32'd20);
    chk("r038_acks1", ack1_n, 32'd20);

    // owner lock holds off the forced switch
    do_reset();
    set_m(0, 1, 1, 0, 32'h8, 4'hF, 0);
    set_m(1, 1, 1, 0, 32'hC, 4'hF, 0);
    cycle();
    ack0_n = 0; ack1_n = 0;
    for (int i = 0; i < 20; i++) cycle();
    chk("r039_acks0", ack0_n, 32'd20);
    chk("r039_acks1", ack1_n, 32'd0);
    set_m(0, 1, 0, 0, 32'h8, 4'hF, 0);
    cycle();
    cycle();
    chk("r039_release", ack1_n, 32'd1);

    // asynchronous reset aborts an m1 write
    do_reset();
    set_m(0, 0, 0, 0, 0, 0, 0);
    set_m(1, 1, 0, 1, 32'h80, 4'hF, 32'hCAFE_F00D);
    cycle();
    #1;
    chk("r040_we_before", {31'b0, ram_we_o}, 32'd1);
    rst = 1'b1;
    model_reset();
    #1;
    chk("r040_we_async", {31'b0, ram_we_o}, 32'd0);
    chk("r040_ack1", {31'b0, m1_if.ack}, 32'd0);
    set_m(0, 1, 0, 0, 32'h80, 4'hF, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    #1;
    chk("r040_tie_m0", {31'b0, m0_if.ack}, 32'd1);
    chk("r040_nowrite", m0_if.rdata, 32'h0);
    cycle();

    // owner drops with no other requester
    set_m(1, 0, 0, 0, 0, 0, 0);
    set_m(0, 0, 0, 1, 32'h84, 4'h3, 32'h1234_5678);
    cycle();
    #1;
    chk("r041_ce", {31'b0, ram_ce_o}, 32'd0);
    chk("r041_addr", ram_addr_o, 32'h0);
    chk("r041_data", ram_data_o, 32'h0);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int m = 0; m < 2; m++) begin
        logic rq;
        rq = (m == 0) ? m0_if.req : m1_if.req;
        if (rq) rq = ($urandom_range(0, 7) != 0);
        else    rq = ($urandom_range(0, 1) != 0);
        set_m(m, rq, $urandom_range(0, 3) == 0,
              1'($urandom_range(0, 1)),
              {24'b0, 4'($urandom_range(0, 15)), 4'b0},
              4'($urandom_range(0, 15)), $urandom);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
